// File: rtl/ras_spill_controller_pkg.sv
// Shared definitions for the return-address stack spill/fill controller:
// decode opcodes for CALL/RET, controller FSM state encoding and the
// saturating statistics helper.
package ras_spill_controller_pkg;

    // Opcodes shared with the branch controller.
    localparam logic [4:0] OPC_CALL = 5'b10000;
    localparam logic [4:0] OPC_RET  = 5'b10001;

    // Controller states: on-chip only, spilling oldest entry, filling a RET.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SPILL = 2'b01,
        ST_FILL  = 2'b10
    } ras_state_e;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    // Increment a 16-bit event counter, holding at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == STAT_MAX) begin
            sat_inc16 = val;
        end else begin
            sat_inc16 = val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/ras_spill_controller_if.sv
// Memory port of the RAS controller: one outstanding word transfer,
// write for spills, read for fills, completed by mem_ack.
interface ras_spill_controller_if #(
    parameter int AWIDTH = 15
);
    logic              mem_req;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [AWIDTH-1:0] mem_wdata;
    logic [AWIDTH-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/ras_spill_controller_ring.sv
// On-chip DEPTH x AWIDTH ring buffer for the return-address stack.
// head points at the next free slot (top is head-1), tail at the oldest
// entry. Operations: push, pop, replace (overwrite top), drop_tail
// (discard oldest after it has been spilled). push and drop_tail may
// occur together; the controller never issues other combinations.
module ras_spill_controller_ring #(
    parameter int AWIDTH = 15,
    parameter int DEPTH  = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_replace,
    input  logic                       i_drop_tail,
    input  logic [AWIDTH-1:0]          i_wdata,
    output logic [AWIDTH-1:0]          o_top,
    output logic [AWIDTH-1:0]          o_tail_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AWIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     w_head_m1;

    assign w_head_m1   = r_head - PW'(1);
    assign o_top       = r_mem[w_head_m1];
    assign o_tail_data = r_mem[r_tail];
    assign o_count     = r_count;

    // Entry storage; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_head] <= i_wdata;
        end else if (i_replace) begin
            r_mem[w_head_m1] <= i_wdata;
        end
    end

    // Head/tail pointers (wrap modulo DEPTH) and occupancy count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_head <= r_head + PW'(1);
            end else if (i_pop) begin
                r_head <= r_head - PW'(1);
            end
            if (i_drop_tail) begin
                r_tail <= r_tail + PW'(1);
            end
            case ({i_push, i_pop, i_drop_tail})
                3'b100:  r_count <= r_count + CW'(1);
                3'b010:  r_count <= r_count - CW'(1);
                3'b001:  r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ras_spill_controller.sv
// Return-address stack with automatic spill/fill to data memory.
// CALLs push into an on-chip ring; when the ring is full the oldest entry
// is written to the spill region first. RETs pop from the ring; when the
// ring is empty the newest spilled entry is read back. stall is raised
// only while such a memory transfer is outstanding and drops in the cycle
// the acknowledge arrives, so the held CALL/RET retires on that edge.
// Optional feature macro: RAS_STATS_EN (spill/fill event counters).
module ras_spill_controller
    import ras_spill_controller_pkg::*;
#(
    parameter int                AWIDTH     = 15,
    parameter int                DEPTH      = 32,
    parameter logic [AWIDTH-1:0] SPILL_BASE = 15'h7C00,
    parameter int                MAX_SPILL  = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_call_req,
    input  logic [AWIDTH-1:0]       i_call_addr,
    input  logic                    i_ret_req,
    output logic [AWIDTH-1:0]       o_ret_addr,
    output logic                    o_ret_valid,
    output logic                    o_stall,
    ras_spill_controller_if.master  mem,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_overflow,
    output logic                    o_underflow,
    output logic [15:0]             o_stat_spills,
    output logic [15:0]             o_stat_fills
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(MAX_SPILL + 1);

    ras_state_e        r_state;
    ras_state_e        w_next_state;
    logic [SW-1:0]     r_spill_cnt;
    logic [AWIDTH-1:0] w_spill_ext;

    logic              w_push;
    logic              w_pop;
    logic              w_replace;
    logic              w_drop_tail;
    logic [AWIDTH-1:0] w_top;
    logic [AWIDTH-1:0] w_tail_data;
    logic [CW-1:0]     w_count;

    logic              w_ring_empty;
    logic              w_ring_full;
    logic              w_spill_empty;
    logic              w_spill_full;
    logic              w_spill_inc;
    logic              w_spill_dec;

    ras_spill_controller_ring #(
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_ring (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_replace   (w_replace),
        .i_drop_tail (w_drop_tail),
        .i_wdata     (i_call_addr),
        .o_top       (w_top),
        .o_tail_data (w_tail_data),
        .o_count     (w_count)
    );

    assign w_ring_empty  = (w_count == CW'(0));
    assign w_ring_full   = (w_count == CW'(DEPTH));
    assign w_spill_empty = (r_spill_cnt == SW'(0));
    assign w_spill_full  = (r_spill_cnt == SW'(MAX_SPILL));
    assign w_spill_ext   = AWIDTH'(r_spill_cnt);

    assign o_full  = w_ring_full && w_spill_full;
    assign o_empty = w_ring_empty && w_spill_empty;

    // Next-state, ring operations, memory port and decode-facing outputs.
    always_comb begin
        w_next_state   = r_state;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_replace      = 1'b0;
        w_drop_tail    = 1'b0;
        w_spill_inc    = 1'b0;
        w_spill_dec    = 1'b0;
        o_ret_addr     = '0;
        o_ret_valid    = 1'b0;
        o_stall        = 1'b0;
        o_overflow     = 1'b0;
        o_underflow    = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_ret_req) begin
                    // RET wins; a simultaneous CALL only matters if the
                    // ring has a top to overwrite.
                    if (!w_ring_empty) begin
                        o_ret_valid = 1'b1;
                        o_ret_addr  = w_top;
                        if (i_call_req) begin
                            w_replace = 1'b1;
                        end else begin
                            w_pop = 1'b1;
                        end
                    end else if (!w_spill_empty) begin
                        w_next_state = ST_FILL;
                        o_stall      = 1'b1;
                    end else begin
                        o_underflow = 1'b1;
                    end
                end else if (i_call_req) begin
                    if (!w_ring_full) begin
                        w_push = 1'b1;
                    end else if (!w_spill_full) begin
                        w_next_state = ST_SPILL;
                        o_stall      = 1'b1;
                    end else begin
                        o_overflow = 1'b1;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SPILL: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = SPILL_BASE + w_spill_ext;
                mem.mem_wdata = w_tail_data;
                if (mem.mem_ack) begin
                    // Oldest entry is now in memory: free its slot and
                    // push the waiting CALL on the same edge.
                    w_drop_tail  = 1'b1;
                    w_push       = i_call_req;
                    w_spill_inc  = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            ST_FILL: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = 1'b0;
                mem.mem_addr = SPILL_BASE + w_spill_ext - AWIDTH'(1);
                if (mem.mem_ack) begin
                    // Filled entry goes straight to the RET; ring untouched.
                    o_ret_valid  = 1'b1;
                    o_ret_addr   = mem.mem_rdata;
                    w_spill_dec  = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any in-flight transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Number of entries currently held in the spill region (never wraps).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_spill_cnt <= '0;
        end else if (w_spill_inc) begin
            r_spill_cnt <= r_spill_cnt + SW'(1);
        end else if (w_spill_dec) begin
            r_spill_cnt <= r_spill_cnt - SW'(1);
        end else begin
            r_spill_cnt <= r_spill_cnt;
        end
    end

`ifdef RAS_STATS_EN
    logic [15:0] r_stat_spills;
    logic [15:0] r_stat_fills;

    // Saturating counts of completed spill and fill transfers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_spills <= 16'h0000;
            r_stat_fills  <= 16'h0000;
        end else begin
            if (w_spill_inc) begin
                r_stat_spills <= sat_inc16(r_stat_spills);
            end
            if (w_spill_dec) begin
                r_stat_fills <= sat_inc16(r_stat_fills);
            end
        end
    end

    assign o_stat_spills = r_stat_spills;
    assign o_stat_fills  = r_stat_fills;
`else
    assign o_stat_spills = 16'h0000;
    assign o_stat_fills  = 16'h0000;
`endif

endmodule

// File: tb/tb_ras_spill_controller.sv
// Bench for ras_spill_controller (DEPTH=4, MAX_SPILL=2): a directed vector
// table, a reset-during-spill sequence, and randomized CALL/RET traffic
// checked against a queue-based stack model.
module tb_ras_spill_controller;
    localparam int          AW    = 15;
    localparam int          DEPTH = 4;
    localparam int          MAXS  = 2;
    localparam logic [14:0] BASE  = 15'h7C00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic [14:0] call_addr = 15'h0000;
    logic [14:0] ret_addr;
    logic        ret_valid, stall, full, empty, overflow, underflow;
    logic [15:0] stat_spills, stat_fills;

    ras_spill_controller_if #(.AWIDTH(AW)) mem_if ();

    ras_spill_controller #(
        .AWIDTH(AW), .DEPTH(DEPTH), .SPILL_BASE(BASE), .MAX_SPILL(MAXS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_call_req(call_req), .i_call_addr(call_addr),
        .i_ret_req(ret_req), .o_ret_addr(ret_addr), .o_ret_valid(ret_valid),
        .o_stall(stall), .mem(mem_if), .o_full(full), .o_empty(empty),
        .o_overflow(overflow), .o_underflow(underflow),
        .o_stat_spills(stat_spills), .o_stat_fills(stat_fills)
    );

    always #5 clk = ~clk;

    // Memory responder: ack arrives mem_lat cycles after the first req cycle.
    logic [14:0] tb_mem [0:32767];
    int          mem_lat = 2;
    int          mem_wait = 0;
    always @(posedge clk) begin
        if (rst) begin
            mem_if.mem_ack <= 1'b0;
            mem_wait       <= 0;
        end else if (mem_if.mem_ack) begin
            mem_if.mem_ack <= 1'b0;
            mem_wait       <= 0;
            if (mem_if.mem_req && mem_if.mem_we) tb_mem[mem_if.mem_addr] <= mem_if.mem_wdata;
        end else if (mem_if.mem_req) begin
            if (mem_wait >= mem_lat - 1) begin
                mem_if.mem_ack   <= 1'b1;
                mem_if.mem_rdata <= tb_mem[mem_if.mem_addr];
            end else begin
                mem_wait <= mem_wait + 1;
            end
        end else begin
            mem_wait <= 0;
        end
    end

    typedef struct {
        logic        call;
        logic        ret;
        logic [14:0] addr;
        logic        rv;
        logic [14:0] ra;
        int          stall_cyc;
        logic        we;
        logic [14:0] maddr;
        logic [14:0] wdata;
        logic        ovf;
        logic        unf;
        logic        full_a;
        logic        empty_a;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int op_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL op%0d %s actual=%0h expected=%0h", op_idx, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic r, input logic [14:0] a,
                                input logic rv, input logic [14:0] ra, input int sc,
                                input logic we, input logic [14:0] maddr, input logic [14:0] wd,
                                input logic ovf, input logic unf, input logic fu, input logic em);
        vec_t v;
        v.call = c; v.ret = r; v.addr = a; v.rv = rv; v.ra = ra; v.stall_cyc = sc;
        v.we = we; v.maddr = maddr; v.wdata = wd; v.ovf = ovf; v.unf = unf;
        v.full_a = fu; v.empty_a = em;
        return v;
    endfunction

    // Present one CALL/RET, hold it while stalled, check it, then one idle cycle.
    task automatic do_op(input vec_t v);
        int cyc = 0;
        @(negedge clk);
        call_req = v.call; ret_req = v.ret; call_addr = v.addr;
        #1;
        while (stall && cyc < 20) begin
            if (cyc > 0) begin
                chk("mem_req", 32'(mem_if.mem_req), 32'd1);
                chk("mem_we", 32'(mem_if.mem_we), 32'(v.we));
                chk("mem_addr", 32'(mem_if.mem_addr), 32'(v.maddr));
                if (v.we) chk("mem_wdata", 32'(mem_if.mem_wdata), 32'(v.wdata));
            end
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 32'(cyc), 32'(v.stall_cyc));
        chk("ret_valid", 32'(ret_valid), 32'(v.rv));
        chk("ret_addr", 32'(ret_addr), 32'(v.ra));
        chk("overflow", 32'(overflow), 32'(v.ovf));
        chk("underflow", 32'(underflow), 32'(v.unf));
        @(negedge clk);
        call_req = 1'b0; ret_req = 1'b0;
        #1;
        chk("full", 32'(full), 32'(v.full_a));
        chk("empty", 32'(empty), 32'(v.empty_a));
        chk("idle_ret_valid", 32'(ret_valid), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        op_idx++;
    endtask

    // Behavioural stack model: on-chip entries and spilled entries as queues.
    logic [14:0] m_ring[$];
    logic [14:0] m_spill[$];
    int          m_nspill = 0;
    int          m_nfill = 0;

    task automatic model_reset();
        m_ring.delete(); m_spill.delete(); m_nspill = 0; m_nfill = 0;
    endtask

    task automatic model_step(input logic c, input logic r, input logic [14:0] a,
                              input int lat, output vec_t v);
        v = mk(c, r, a, 1'b0, 15'h0, 0, 1'b0, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (r && m_ring.size() > 0) begin
            v.rv = 1'b1;
            v.ra = m_ring[m_ring.size()-1];
            if (c) m_ring[m_ring.size()-1] = a;
            else void'(m_ring.pop_back());
        end else if (r) begin
            if (m_spill.size() > 0) begin
                v.stall_cyc = lat + 1;
                v.maddr = BASE + 15'(m_spill.size() - 1);
                v.rv = 1'b1;
                v.ra = m_spill.pop_back();
                m_nfill++;
            end else begin
                v.unf = 1'b1;
            end
        end else if (c) begin
            if (m_ring.size() < DEPTH) begin
                m_ring.push_back(a);
            end else if (m_spill.size() < MAXS) begin
                v.stall_cyc = lat + 1;
                v.we = 1'b1;
                v.maddr = BASE + 15'(m_spill.size());
                v.wdata = m_ring[0];
                m_spill.push_back(m_ring.pop_front());
                m_ring.push_back(a);
                m_nspill++;
            end else begin
                v.ovf = 1'b1;
            end
        end
        v.full_a  = (m_ring.size() == DEPTH) && (m_spill.size() == MAXS);
        v.empty_a = (m_ring.size() == 0) && (m_spill.size() == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; call_req = 1'b0; ret_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t tbl[32];
    vec_t v;

    initial begin
        // Directed table: state after each op noted in full/empty columns.
        //            c     r     addr    rv    ra      sc we    maddr    wdata   ovf   unf   full  empty
        tbl[0]  = mk(1'b1, 1'b0, 15'h10, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 15'h11, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 15'h12, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h12, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h11, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h10, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b1, 15'h0,  1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b1, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 1'b0, 15'h20, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 15'h21, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 15'h22, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 15'h23, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 15'h24, 1'b0, 15'h0,  3, 1'b1, 15'h7C00, 15'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h24, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h23, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h22, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h21, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h20, 3, 1'b0, 15'h7C00, 15'h0,  1'b0, 1'b0, 1'b0, 1'b1);
        tbl[17] = mk(1'b1, 1'b0, 15'h40, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 15'h41, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[19] = mk(1'b1, 1'b0, 15'h42, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[20] = mk(1'b1, 1'b0, 15'h43, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[21] = mk(1'b1, 1'b0, 15'h44, 1'b0, 15'h0,  3, 1'b1, 15'h7C00, 15'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[22] = mk(1'b1, 1'b0, 15'h45, 1'b0, 15'h0,  3, 1'b1, 15'h7C01, 15'h41, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[23] = mk(1'b1, 1'b0, 15'h46, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b1, 1'b0, 1'b1, 1'b0);
        tbl[24] = mk(1'b1, 1'b1, 15'h50, 1'b1, 15'h45, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b1, 1'b0);
        tbl[25] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h50, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[26] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h44, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[27] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h43, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[28] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h42, 0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[29] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h41, 3, 1'b0, 15'h7C01, 15'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[30] = mk(1'b0, 1'b1, 15'h0,  1'b1, 15'h40, 3, 1'b0, 15'h7C00, 15'h0,  1'b0, 1'b0, 1'b0, 1'b1);
        tbl[31] = mk(1'b1, 1'b1, 15'h55, 1'b0, 15'h0,  0, 1'b0, 15'h0,    15'h0,  1'b0, 1'b1, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("rst_ret_valid", 32'(ret_valid), 32'd0);
        chk("rst_ret_addr", 32'(ret_addr), 32'd0);
        chk("rst_ovf_unf", 32'({overflow, underflow}), 32'd0);
        chk("rst_stats", 32'({stat_spills, stat_fills}), 32'd0);

        mem_lat = 2;
        for (int i = 0; i < 32; i++) do_op(tbl[i]);
`ifdef RAS_STATS_EN
        chk("stat_spills_tbl", 32'(stat_spills), 32'd3);
        chk("stat_fills_tbl", 32'(stat_fills), 32'd3);
`else
        chk("stat_spills_tbl", 32'(stat_spills), 32'd0);
        chk("stat_fills_tbl", 32'(stat_fills), 32'd0);
`endif

        // Reset while a spill is waiting for its ack.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            model_step(1'b1, 1'b0, 15'(16'h60 + i), mem_lat, v);
            do_op(v);
        end
        @(negedge clk);
        call_req = 1'b1; call_addr = 15'h35;
        #1;
        chk("rs_req_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("rs_spill_req", 32'(mem_if.mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; call_req = 1'b0;
        model_reset();
        #1;
        chk("rs_mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("rs_stall", 32'(stall), 32'd0);
        chk("rs_empty", 32'(empty), 32'd1);
        model_step(1'b1, 1'b0, 15'h30, mem_lat, v);
        do_op(v);
        model_step(1'b0, 1'b1, 15'h0, mem_lat, v);
        chk("rs_model_ret", 32'(v.ra), 32'h30);
        do_op(v);

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int          sel;
            logic        c, r;
            sel = int'($urandom_range(0, 99));
            c = (sel < 45) || (sel >= 80);
            r = (sel >= 45);
            mem_lat = int'($urandom_range(1, 3));
            model_step(c, r, 15'($urandom), mem_lat, v);
            do_op(v);
        end
`ifdef RAS_STATS_EN
        chk("stat_spills_rnd", 32'(stat_spills), 32'(m_nspill));
        chk("stat_fills_rnd", 32'(stat_fills), 32'(m_nfill));
`else
        chk("stat_spills_rnd", 32'(stat_spills), 32'd0);
        chk("stat_fills_rnd", 32'(stat_fills), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
